vga_timing_gen: RTL and testbench

//  Source end of the VGA bus (VGA_BUS_SIZE, fields packed with the macros in verilog_macro_bus.vh).

---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// VGA raster bus: pixel position, sync/blank flags and colour for one pixel clock.
// The source drives the fields; sinks read them individually or as the packed word.
interface vga_timing_gen_if;
  localparam int VGA_BUS_SIZE = 38;

  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;
  logic [VGA_BUS_SIZE-1:0] bus;

  // Packed layout: {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb}
  assign bus = {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb};

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );

  modport slave (
    input hcount, hsync, hblnk, vcount, vsync, vblnk, rgb, bus
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters with registered sync and blanking decode,
// frame-origin pulse and completed-frame counter, all advancing on the pixel enable.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  ce,
  vga_timing_gen_if.master      vga_out,
  output logic                  frame_start,
  output logic [7:0]            frame_cnt
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  logic [1:0][10:0] cnt_reg;
  logic [1:0][10:0] cnt_next;
  logic [1:0]       wrap;
  logic [1:0]       adv;
  logic [1:0]       blnk_reg;
  logic [1:0]       blnk_next;
  logic [1:0]       sync_reg;
  logic [1:0]       sync_next;
  logic             frame_start_reg;
  logic [7:0]       frame_cnt_reg;
  logic             frame_wrap;

  // Lines only advance on the pixel that ends a line.
  assign adv[0] = 1'b1;
  assign adv[1] = wrap[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int VIS   = (gi == 0) ? H_VISIBLE : V_VISIBLE;
      localparam int TOTAL = (gi == 0) ? H_TOTAL   : V_TOTAL;
      localparam int SS    = (gi == 0) ? (H_VISIBLE + H_FP) : (V_VISIBLE + V_FP);
      localparam int SE    = (gi == 0) ? (SS + H_SYNC) : (SS + V_SYNC);
      localparam logic [10:0] LAST      = 11'(TOTAL - 1);
      localparam logic [10:0] VIS_C     = 11'(VIS);
      localparam logic [10:0] SYNC_BEG  = 11'(SS);
      localparam logic [10:0] SYNC_END  = 11'(SE);

      assign wrap[gi] = (cnt_reg[gi] == LAST);

      assign cnt_next[gi] = !adv[gi] ? cnt_reg[gi]
                          : (wrap[gi] ? 11'd0 : cnt_reg[gi] + 11'd1);

      // Decode from the next count so flags land in the same cycle as the count.
      assign blnk_next[gi] = (cnt_next[gi] >= VIS_C);
      assign sync_next[gi] = ((cnt_next[gi] >= SYNC_BEG) && (cnt_next[gi] < SYNC_END))
                             ? SYNC_POL : SYNC_IDLE;
    end
  endgenerate

  assign frame_wrap = wrap[0] & wrap[1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_reg         <= '0;
      blnk_reg        <= '0;
      sync_reg        <= {SYNC_IDLE, SYNC_IDLE};
      frame_start_reg <= 1'b1;
      frame_cnt_reg   <= 8'd0;
    end else if (ce) begin
      cnt_reg         <= cnt_next;
      blnk_reg        <= blnk_next;
      sync_reg        <= sync_next;
      frame_start_reg <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end else begin
      frame_start_reg <= 1'b0;
    end
  end

  assign vga_out.hcount = cnt_reg[0];
  assign vga_out.hsync  = sync_reg[0];
  assign vga_out.hblnk  = blnk_reg[0];
  assign vga_out.vcount = cnt_reg[1];
  assign vga_out.vsync  = sync_reg[1];
  assign vga_out.vblnk  = blnk_reg[1];
  assign vga_out.rgb    = 12'h000;

  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (16x10), with both sync polarities
// running side by side against a linear pixel-index reference.
module tb_vga_timing_gen;
  localparam int HV = 8, HFP = 2, HSY = 4, HBP = 2;
  localparam int VV = 5, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic ce   = 1'b0;
  always #5 pclk = ~pclk;

  vga_timing_gen_if vga_p ();
  vga_timing_gen_if vga_n ();
  logic       fs_p, fs_n;
  logic [7:0] fc_p, fc_n;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)
  ) dut_p (
    .pclk(pclk), .rst(rst), .ce(ce), .vga_out(vga_p.master),
    .frame_start(fs_p), .frame_cnt(fc_p)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .rst(rst), .ce(ce), .vga_out(vga_n.master),
    .frame_start(fs_n), .frame_cnt(fc_n)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: position as a single index into the frame.
  int m_p  = 0;
  int m_fc = 0;
  bit m_fs = 1'b0;

  typedef struct {
    bit rst;
    bit ce;
    int n;
    int h;
    int v;
    bit hb;
    bit hs;
    bit vb;
    bit vs;
    bit fs;
    int fc;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [46:0] pack(int h, int v, bit hb, bit hs_act, bit vb, bit vs_act,
                                       bit fs, int fc, bit pol);
    logic hsl, vsl;
    hsl = hs_act ? pol : ~pol;
    vsl = vs_act ? pol : ~pol;
    return {11'(h), hsl, hb, 11'(v), vsl, vb, 12'h000, fs, 8'(fc)};
  endfunction

  function automatic logic [46:0] model_vec(bit pol);
    int h, v;
    h = m_p % HT;
    v = m_p / HT;
    return pack(h, v, h >= HV, (h >= HV + HFP) && (h < HV + HFP + HSY),
                v >= VV, (v >= VV + VFP) && (v < VV + VFP + VSY), m_fs, m_fc, pol);
  endfunction

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit c);
    rst = r;
    ce  = c;
    @(posedge pclk);
    #1;
    if (r) begin
      m_p  = 0;
      m_fc = 0;
      m_fs = 1'b1;
    end else if (c) begin
      m_p = (m_p + 1) % FRAME;
      m_fs = (m_p == 0);
      if (m_p == 0) m_fc = (m_fc + 1) % 256;
    end else begin
      m_fs = 1'b0;
    end
    check("model_pos", {vga_p.bus, fs_p, fc_p}, model_vec(1'b1));
    check("model_neg", {vga_n.bus, fs_n, fc_n}, model_vec(1'b0));
  endtask

  initial begin
    if (HT > 2048 || VT > 2048) $error("unsupported raster: H_TOTAL=%0d V_TOTAL=%0d", HT, VT);

    //            rst ce  n    h  v  hb hs vb vs fs fc
    tbl[0]  = '{1, 0, 3,   0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 7,   8, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 2,  10, 0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 5,  10, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 5,  15, 0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1,   0, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 64,  0, 5, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 16,  0, 6, 0, 0, 1, 1, 0, 0};
    tbl[9]  = '{0, 1, 63, 15, 9, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 106, 11, 6, 1, 1, 1, 1, 0, 1};
    tbl[13] = '{1, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].ce);
      check($sformatf("tbl%0d_pos", i), {vga_p.bus, fs_p, fc_p},
            pack(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].hs, tbl[i].vb, tbl[i].vs,
                 tbl[i].fs, tbl[i].fc, 1'b1));
      check($sformatf("tbl%0d_neg", i), {vga_n.bus, fs_n, fc_n},
            pack(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].hs, tbl[i].vb, tbl[i].vs,
                 tbl[i].fs, tbl[i].fc, 1'b0));
      $display("row %0d: rst=%0b ce=%0b x%0d -> h=%0d v=%0d hsync=%0b vsync=%0b fs=%0b fc=%0d",
               i, tbl[i].rst, tbl[i].ce, tbl[i].n, vga_p.hcount, vga_p.vcount,
               vga_p.hsync, vga_p.vsync, fs_p, fc_p);
    end

    // Random enable gaps and occasional resets against the reference.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    end
    $display("random: 3000 cycles, now h=%0d v=%0d fc=%0d", vga_p.hcount, vga_p.vcount, fc_p);

    // Frame counter wrap: 255 frames, then one more rolls it to zero.
    step(1'b1, 1'b0);
    for (int k = 0; k < 255 * FRAME; k++) step(1'b0, 1'b1);
    check("fc_255", {vga_p.bus, fs_p, fc_p}, pack(0, 0, 0, 0, 0, 0, 1'b1, 255, 1'b1));
    $display("after 255 frames: h=%0d v=%0d fs=%0b fc=%0d", vga_p.hcount, vga_p.vcount, fs_p, fc_p);
    for (int k = 0; k < FRAME; k++) step(1'b0, 1'b1);
    check("fc_wrap", {vga_p.bus, fs_p, fc_p}, pack(0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b1));
    check("fc_wrap_neg", {vga_n.bus, fs_n, fc_n}, pack(0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0));
    $display("after 256 frames: h=%0d v=%0d fs=%0b fc=%0d", vga_p.hcount, vga_p.vcount, fs_p, fc_p);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
